// File: rtl/commit_trace_buf.sv
// commit_trace_buf: records every committed PC together with the number of
// idle cycles since the previous commit into a circular buffer. A reader
// drains the buffer over a valid/ready port. Sticky overflow and hang flags
// help during bring-up.
module commit_trace_buf #(
  parameter int DEPTH       = 16,
  parameter int GAP_W       = 16,
  parameter int HANG_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wb_valid,
  input  logic [31:0]                wb_pc,
  input  logic                       freeze,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [31:0]                rd_pc,
  output logic [GAP_W-1:0]           rd_gap,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       hang,
  output logic [31:0]                commit_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(HANG_CYCLES + 1);

  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_FULL  = CW'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_MAX   = {GAP_W{1'b1}};
  localparam logic [IW-1:0]    IDLE_MAX  = IW'(HANG_CYCLES);
  localparam logic [IW-1:0]    IDLE_LAST = IW'(HANG_CYCLES - 1);

  logic [31:0]      pc_mem  [DEPTH];
  logic [GAP_W-1:0] gap_mem [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic [IW-1:0]    idle_cnt;

  logic push;
  logic pop;
  logic full;

  // A frozen commit still counts as a commit; it just is not stored.
  assign push     = wb_valid && !freeze;
  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready;
  assign full     = (count == CNT_FULL);

  assign rd_pc  = pc_mem[rd_ptr];
  assign rd_gap = gap_mem[rd_ptr];

  // Entry storage; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      pc_mem[wr_ptr]  <= wb_pc;
      gap_mem[wr_ptr] <= gap_cnt;
    end
  end

  // Pointer and occupancy bookkeeping; a push into a full buffer drags the
  // read pointer along so the oldest entry is the one lost or consumed.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop || (push && full)) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop && !full) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Cycles since the last commit, saturating, captured with each push.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      gap_cnt <= '0;
    end else if (wb_valid) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_MAX) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // Idle watchdog: hang latches when the idle run reaches HANG_CYCLES.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idle_cnt <= '0;
      hang     <= 1'b0;
    end else begin
      if (wb_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (!wb_valid && idle_cnt == IDLE_LAST) begin
        hang <= 1'b1;
      end
    end
  end

  // Total commit counter, frozen commits included, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      commit_cnt <= '0;
    end else if (wb_valid) begin
      commit_cnt <= commit_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_commit_trace_buf.sv
// tb_commit_trace_buf: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the trace buffer.
module tb_commit_trace_buf;

  localparam int DEPTH       = 8;
  localparam int GAP_W       = 4;
  localparam int HANG_CYCLES = 40;
  localparam int GAP_SAT     = (1 << GAP_W) - 1;

  logic                   clk;
  logic                   resetn;
  logic                   wb_valid;
  logic [31:0]            wb_pc;
  logic                   freeze;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [31:0]            rd_pc;
  logic [GAP_W-1:0]       rd_gap;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   hang;
  logic [31:0]            commit_cnt;

  int errors;
  int checks;

  // Reference model state
  logic [31:0] m_pc[$];
  int          m_gap[$];
  int          m_idle;
  bit          m_overflow;
  bit          m_hang;
  logic [31:0] m_commits;

  commit_trace_buf #(
    .DEPTH(DEPTH),
    .GAP_W(GAP_W),
    .HANG_CYCLES(HANG_CYCLES)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .wb_valid(wb_valid),
    .wb_pc(wb_pc),
    .freeze(freeze),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_pc(rd_pc),
    .rd_gap(rd_gap),
    .count(count),
    .overflow(overflow),
    .hang(hang),
    .commit_cnt(commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("count", 64'(count), 64'(m_pc.size()));
    checkOutput("rd_valid", 64'(rd_valid), 64'(m_pc.size() != 0));
    checkOutput("overflow", 64'(overflow), 64'(m_overflow));
    checkOutput("hang", 64'(hang), 64'(m_hang));
    checkOutput("commit_cnt", 64'(commit_cnt), 64'(m_commits));
    if (m_pc.size() != 0) begin
      checkOutput("rd_pc", 64'(rd_pc), 64'(m_pc[0]));
      checkOutput("rd_gap", 64'(rd_gap), 64'(m_gap[0]));
    end
  endtask

  task automatic modelReset();
    m_pc.delete();
    m_gap.delete();
    m_idle     = 0;
    m_overflow = 0;
    m_hang     = 0;
    m_commits  = '0;
  endtask

  // One clock with the given inputs; the model advances from the same inputs.
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic frz, input logic rdy);
    wb_valid = v;
    wb_pc    = pc;
    freeze   = frz;
    rd_ready = rdy;
    @(posedge clk);
    if (rdy && m_pc.size() != 0) begin
      void'(m_pc.pop_front());
      void'(m_gap.pop_front());
    end
    if (v && !frz) begin
      m_pc.push_back(pc);
      m_gap.push_back(m_idle > GAP_SAT ? GAP_SAT : m_idle);
      if (m_pc.size() > DEPTH) begin
        void'(m_pc.pop_front());
        void'(m_gap.pop_front());
        m_overflow = 1;
      end
    end
    if (v) begin
      m_commits = m_commits + 32'd1;
      m_idle    = 0;
    end else begin
      m_idle++;
      if (m_idle >= HANG_CYCLES) m_hang = 1;
    end
    #1;
    checkAll();
  endtask

  task automatic doReset();
    resetn   = 1'b0;
    wb_valid = 1'b1;
    wb_pc    = 32'hDEAD_BEEF;
    freeze   = 1'b0;
    rd_ready = 1'b1;
    @(posedge clk);
    modelReset();
    #1;
    resetn = 1'b1;
    checkAll();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    modelReset();
    resetn   = 1'b0;
    wb_valid = 1'b0;
    wb_pc    = '0;
    freeze   = 1'b0;
    rd_ready = 1'b0;
    @(posedge clk);
    doReset();
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);

    // Three back-to-back commits, no reader
    applyStimulus(1'b1, 32'hBFC0_0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBFC0_0004, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBFC0_0008, 1'b0, 1'b0);
    checkOutput("t1_count", 64'(count), 64'd3);
    checkOutput("t1_pc", 64'(rd_pc), 64'hBFC0_0000);
    checkOutput("t1_gap", 64'(rd_gap), 64'd0);
    checkOutput("t1_commits", 64'(commit_cnt), 64'd3);

    // Two commits five idle cycles apart, then drain
    doReset();
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_2000, 1'b0, 1'b0);
    checkOutput("t2_gap0", 64'(rd_gap), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t2_pc1", 64'(rd_pc), 64'h0000_2000);
    checkOutput("t2_gap1", 64'(rd_gap), 64'd5);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t2_empty", 64'(rd_valid), 64'd0);
    checkOutput("t2_count", 64'(count), 64'd0);

    // Overfill by two
    doReset();
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
    checkOutput("t3_count", 64'(count), 64'(DEPTH));
    checkOutput("t3_ovf", 64'(overflow), 64'd1);
    checkOutput("t3_pc", 64'(rd_pc), 64'h108);

    // Full buffer with simultaneous push and pop
    doReset();
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h900, 1'b0, 1'b1);
    checkOutput("t4_count", 64'(count), 64'(DEPTH));
    checkOutput("t4_ovf", 64'(overflow), 64'd0);
    checkOutput("t4_pc", 64'(rd_pc), 64'h104);

    // Frozen commits
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
    checkOutput("t5_count", 64'(count), 64'd0);
    checkOutput("t5_commits", 64'(commit_cnt), 64'd4);
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
    checkOutput("t5_gap", 64'(rd_gap), 64'd0);
    checkOutput("t5_pc", 64'(rd_pc), 64'h300);

    // Hang watchdog, then reset clears everything sticky
    doReset();
    for (int i = 0; i < HANG_CYCLES - 1; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6_nohang", 64'(hang), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6_hang", 64'(hang), 64'd1);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
    checkOutput("t6_hang_kept", 64'(hang), 64'd1);
    checkOutput("t6_gap_sat", 64'(rd_gap), 64'd0);
    doReset();
    checkOutput("t6_rst_hang", 64'(hang), 64'd0);
    checkOutput("t6_rst_ovf", 64'(overflow), 64'd0);
    checkOutput("t6_rst_commits", 64'(commit_cnt), 64'd0);

    // Gap saturation boundary
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0);
    for (int i = 0; i < GAP_SAT + 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h504, 1'b0, 1'b1);
    checkOutput("t7_gap_sat", 64'(rd_gap), 64'(GAP_SAT));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
      end else if ($urandom_range(0, 19) == 0) begin
        int len;
        len = $urandom_range(5, 50);
        for (int k = 0; k < len; k++)
          applyStimulus(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(1'($urandom_range(0, 9) < 6), $urandom,
                      1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) < 4));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_trace_buf.md
# commit_trace_buf

Commit-trace capture block sitting directly downstream of the CPU top's display outputs. It consumes the writeback commit stream (wb_valid, wb_pc) and records each committed PC, plus the cycle gap since the previous commit, into a circular buffer. The buffer is drained by a debug/display reader over a valid/ready port. Sticky overflow and hang flags support board bring-up and the simulation benches.

## Interface
- DEPTH, 16, buffer entries; power of two, 2..256
- GAP_W, 16, width of the per-entry gap field; saturating
- HANG_CYCLES, 1024, consecutive commit-free cycles that raise hang; must be ≥1
- clk  input  1  sole clock; all state updates on rising edge
- resetn  input  1  reset, synchronous, active-low
- wb_valid  input  1  one instruction committed this cycle
- wb_pc  input  32  PC of the committed instruction; sampled only when wb_valid=1
- freeze  input  1  1 = suppress buffer pushes; counters keep running
- rd_valid  output  1  buffer non-empty; head entry presented
- rd_ready  input  1  reader accepts head when rd_valid=1
- rd_pc  output  32  PC of head entry
- rd_gap  output  GAP_W  gap field of head entry
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: an unread entry was overwritten
- hang  output  1  sticky: HANG_CYCLES consecutive cycles with no commit
- commit_cnt  output  32  total commits since reset, wraps modulo 2^32

## Operation
- Storage: DEPTH entries of {pc, gap}; write pointer, read pointer, occupancy counter.
- Push condition: wb_valid=1 and freeze=0. The pushed entry is {wb_pc, gap_cnt}.
- Gap counter gap_cnt:
  - resets to 0;
  - on any wb_valid=1 cycle, whether or not frozen, it loads 0 next cycle;
  - otherwise it increments, saturating at 2^GAP_W−1.
  - Result: back-to-back commits record gap 0; commits separated by k idle cycles record gap k.
- Pop condition: rd_valid=1 and rd_ready=1. The read pointer advances.
- Push with count<DEPTH: entry written at the write pointer, write pointer advances, count+1. A simultaneous pop leaves count unchanged.
- Push with count==DEPTH and no pop: the oldest entry is overwritten; both pointers advance; count stays DEPTH; overflow set.
- Push with count==DEPTH plus a pop: the pop consumes the oldest entry and the push fills its slot; no overflow; count stays DEPTH.
- Pop with count==0 is impossible (rd_valid=0). rd_ready is ignored when empty.
- Pointers wrap modulo DEPTH.
- Idle counter: resets to 0, clears on wb_valid=1, otherwise increments and saturates at HANG_CYCLES. hang sets on the cycle the idle counter reaches HANG_CYCLES and stays set until reset; a later commit does not clear it.
- commit_cnt increments on every wb_valid=1 cycle, including while freeze=1.
- rd_pc and rd_gap are driven from storage at the read pointer. Their values are don't-care when rd_valid=0.
- Reset (resetn=0 at a clock edge) overrides all other activity, including mid-burst: pointers, count, gap_cnt, the idle counter, commit_cnt, overflow and hang all go to 0. Storage contents are not cleared.

## Timing
- Reset values: rd_valid=0, count=0, overflow=0, hang=0, commit_cnt=0. rd_pc and rd_gap are undefined.
- Push latency is 1 cycle: a commit at edge N is visible on rd_valid/rd_pc/count after edge N.
- Pop takes effect at the edge where rd_valid&rd_ready=1. The next entry, or rd_valid=0, appears the following cycle.
- rd_valid/rd_pc/rd_gap do not depend combinationally on rd_ready. All outputs are registered or driven from registered state.
- A reader may hold rd_ready=1 continuously to drain one entry per cycle.
- overflow and hang assert one cycle after the triggering edge condition.
- freeze is sampled per cycle. No pipeline delay: a commit in the same cycle freeze goes 1 is not captured.

## Test plan
- Reset then three commits on consecutive cycles (PC 0xBFC00000, 0xBFC00004, 0xBFC00008), rd_ready=0 -> count=3, head PC 0xBFC00000 with gap 0, commit_cnt=3.
- Two commits separated by 5 idle cycles, then drain with rd_ready=1 -> entries read with gaps {g0, 5} in order, rd_valid drops the cycle after the second pop, count=0.
- DEPTH+2 commits (PC 0x100+4i) with rd_ready=0 -> count=DEPTH, overflow=1, head PC 0x108.
- count=DEPTH, then a push and a pop in the same cycle -> count=DEPTH, overflow remains 0, head advances by one entry.
- freeze=1 during 4 commits -> count unchanged, commit_cnt +4, and the next unfrozen commit records gap 0 if it follows immediately.
- No commits for HANG_CYCLES cycles after reset -> hang=1 on the next cycle. A subsequent commit leaves hang=1. Asserting resetn=0 for one edge clears hang, overflow, count and commit_cnt.
